// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: frame FSM, serializer, parity and line driver in one block.
// Optional line-break support is enabled by defining UART_TX_BREAK_EN.
module uart_tx_param #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick_in,
`ifdef UART_TX_BREAK_EN
    input  logic                  break_in,
`endif
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  par_en_in,
    input  logic                  par_type_in,
    input  logic                  stop2_in,
    output logic                  data_ack_out,
    output logic                  tx_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK  = 3'd6;
`endif

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic                  frame_end;

    // State and output registers; pulses self-clear, everything else holds without a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; tx_d is the line level of the state being entered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        frame_end = 1'b0;

        if (tick_in) begin
            case (state_q)
                S_IDLE: begin
                end
                S_START: begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                end
                S_DATA: begin
                    if (cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + BIT_CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP1;
                    tx_d    = 1'b1;
                end
                S_STOP1: begin
                    if (stop2_q) begin
                        state_d = S_STOP2;
                        tx_d    = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
                S_STOP2: begin
                    frame_end = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (!break_in) begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase

            // Accept window: idle, or the end tick of a frame (back-to-back without an idle bit).
            if ((state_q == S_IDLE) || frame_end) begin
                done_d = frame_end;
`ifdef UART_TX_BREAK_EN
                if (break_in) begin
                    state_d = S_BREAK;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else
`endif
                if (data_valid_in) begin
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    ack_d     = 1'b1;
                    shift_d   = data_in;
                    par_en_d  = par_en_in;
                    par_bit_d = par_type_in ? ~^data_in : ^data_in;
                    stop2_d   = stop2_in;
                end else begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
        end
    end

    assign data_ack_out   = ack_q;
    assign tx_out         = tx_q;
    assign busy_out       = busy_q;
    assign frame_done_out = done_q;

endmodule
